// File: rtl/cap_ram_rd_mb_pkg.sv
// cap_ram_pkg: shared types for the capture RAM read controller.
//   src_e  : which requester a RAM read belongs to
//   st_e   : debug stream FSM states
//   tag_t  : per-read tag that travels alongside the RAM read latency
//   clog2  : constant-function ceil(log2(v))
package cap_ram_pkg;

    typedef enum logic {
        SRC_HOST = 1'b0,
        SRC_DBG  = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } st_e;

    // Bank select is carried at a fixed generous width so the struct does not
    // depend on NUM_BANKS; only the low clog2(NUM_BANKS) bits are ever nonzero.
    localparam int TAG_BSEL_W = 8;

    typedef struct packed {
        logic                  vld;
        src_e                  src;
        logic [TAG_BSEL_W-1:0] bsel;
        logic                  wide;
    } tag_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bus_delay.sv
// bus_delay: fixed-latency register pipeline.
//   clk, rst_n : clock, asynchronous active-high reset (clears every stage)
//   d_i        : W-bit input
//   q_o        : d_i delayed by DEPTH cycles (DEPTH >= 1)
module bus_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/cap_ram_rd_mb_fifo.sv
// cap_rd_fifo: synchronous FIFO, DEPTH x W, first-word-fall-through head.
//   clk, rst_n : clock, asynchronous active-high reset
//   push_i     : write din_i (caller guarantees not full)
//   pop_i      : drop head (caller guarantees not empty)
//   dout_o     : current head entry
//   empty_o    : no entries
//   count_o    : number of entries held
module cap_rd_fifo
    import cap_ram_pkg::*;
#(
    parameter  int W     = 64,
    parameter  int DEPTH = 8,
    localparam int PW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
        else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_inc(wptr_q);
            if (pop_i)  rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/cap_ram_rd_mb.sv
// cap_ram_rd_mb: multi-bank read controller for the capture RAM.
// Serves one-shot host register reads and an auto-incrementing debug stream
// from NUM_BANKS single-port banks, in deep (address MSBs pick a bank) or wide
// (all banks concatenated) store mode.
// Ports:
//   clk, rst_n                 clock, asynchronous active-high reset
//   capture_mode/cap_dbg_mode  stream path active when equal (host reads ignored)
//   store_mode                 1 = wide, 0 = deep
//   capture_max_addr           stream wrap address, inclusive
//   capture_rd_en/_addr        host read strobe/address
//   capture_rd_vld/_data       host read return, data held until next valid
//   dbg_rd_en                  stream enable (level)
//   dbg_rd_vld/_rdy/_data      stream output, ready/valid
//   ram_rd_en/ram_raddr        registered per-bank read enable/address
//   ram_rdata                  per-bank read data, RAM_READ_DELAY after ram_rd_en
// Optional build macro CAP_RD_ADDR_TAG_EN adds capture_rd_addr_o/dbg_rd_addr_o,
// the address of each returned word, aligned with its valid.
module cap_ram_rd_mb
    import cap_ram_pkg::*;
#(
    parameter  int NUM_BANKS      = 4,
    parameter  int BANK_DW        = 16,
    parameter  int BANK_AW        = 13,
    parameter  int RAM_READ_DELAY = 2,
    parameter  int MODE_WIDTH     = 4,
    parameter  int FIFO_DEPTH     = 8,
    localparam int BSEL_W         = clog2(NUM_BANKS),
    localparam int AW             = BANK_AW + BSEL_W,
    localparam int DW             = NUM_BANKS * BANK_DW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MODE_WIDTH-1:0]        capture_mode,
    input  logic [MODE_WIDTH-1:0]        cap_dbg_mode,
    input  logic                         store_mode,
    input  logic [AW-1:0]                capture_max_addr,
    input  logic                         capture_rd_en,
    input  logic [AW-1:0]                capture_rd_addr,
    output logic                         capture_rd_vld,
    output logic [DW-1:0]                capture_rd_data,
    input  logic                         dbg_rd_en,
    output logic                         dbg_rd_vld,
    input  logic                         dbg_rd_rdy,
    output logic [DW-1:0]                dbg_rd_data,
    output logic [NUM_BANKS-1:0]         ram_rd_en,
    output logic [NUM_BANKS*BANK_AW-1:0] ram_raddr,
    input  logic [NUM_BANKS*BANK_DW-1:0] ram_rdata
`ifdef CAP_RD_ADDR_TAG_EN
    ,
    output logic [AW-1:0]                capture_rd_addr_o,
    output logic [AW-1:0]                dbg_rd_addr_o
`endif
);

    localparam int CW = clog2(FIFO_DEPTH + 1);
`ifdef CAP_RD_ADDR_TAG_EN
    localparam int FW = DW + AW;
`else
    localparam int FW = DW;
`endif

    st_e                         state_q, state_d;
    logic [AW-1:0]               ptr_q, ptr_d, ptr_nxt;
    logic [BANK_AW-1:0]          ptr_lo_inc;
    logic [CW-1:0]               infl_q, infl_d, fifo_cnt;
    logic                        fifo_empty, fifo_pop;
    logic [FW-1:0]               fifo_din, fifo_dout;

    logic                        active, host_req, dbg_req, req, credit_ok;
    logic [AW-1:0]               req_addr;
    logic [BSEL_W-1:0]           req_bsel;
    logic [NUM_BANKS-1:0]        ram_rd_en_d, ram_rd_en_q;
    logic [NUM_BANKS*BANK_AW-1:0] ram_raddr_q;
    tag_t                        tag_d, tag_q, ret_tag;

    logic                        host_ret, dbg_ret;
    logic [BANK_DW-1:0]          ret_bank;
    logic [DW-1:0]               ret_data, cap_data_q;
    logic                        cap_vld_q;

    // ---------------- request side ----------------
    always_comb begin
        active    = (capture_mode == cap_dbg_mode);
        host_req  = capture_rd_en && !active;
        // Every outstanding stream read owns a FIFO slot from issue to pop.
        credit_ok = ({1'b0, infl_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
        // Stream only issues while active, so it never collides with a host read.
        dbg_req   = (state_q == ST_STREAM) && dbg_rd_en && active && credit_ok;
        req       = host_req || dbg_req;
        req_addr  = host_req ? capture_rd_addr
                             : (store_mode ? AW'(ptr_q[BANK_AW-1:0]) : ptr_q);
        req_bsel  = req_addr[AW-1:BANK_AW];

        ram_rd_en_d = '0;
        if (req) begin
            if (store_mode) ram_rd_en_d = '1;
            else            ram_rd_en_d[req_bsel] = 1'b1;
        end

        tag_d.vld  = req;
        tag_d.src  = host_req ? SRC_HOST : SRC_DBG;
        tag_d.bsel = TAG_BSEL_W'(req_bsel);
        tag_d.wide = store_mode;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ram_rd_en_q <= '0;
            ram_raddr_q <= '0;
            tag_q       <= '0;
        end else begin
            ram_rd_en_q <= ram_rd_en_d;
            if (req) ram_raddr_q <= {NUM_BANKS{req_addr[BANK_AW-1:0]}};
            tag_q       <= tag_d;
        end
    end

    assign ram_rd_en = ram_rd_en_q;
    assign ram_raddr = ram_raddr_q;

    // Tag lines up with ram_rdata: one register stage above plus the RAM latency.
    bus_delay #(.W($bits(tag_t)), .DEPTH(RAM_READ_DELAY)) u_tag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tag_q),
        .q_o   (ret_tag)
    );

    // ---------------- return side: routed by tag, not by current mode ----------------
    always_comb begin
        host_ret = ret_tag.vld && (ret_tag.src == SRC_HOST);
        dbg_ret  = ret_tag.vld && (ret_tag.src == SRC_DBG);
        ret_bank = ram_rdata[ret_tag.bsel*BANK_DW +: BANK_DW];
        ret_data = ret_tag.wide ? ram_rdata : DW'(ret_bank);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cap_vld_q  <= 1'b0;
            cap_data_q <= '0;
        end else begin
            cap_vld_q <= host_ret;
            if (host_ret) cap_data_q <= ret_data;
        end
    end

    assign capture_rd_vld  = cap_vld_q;
    assign capture_rd_data = cap_data_q;

    // ---------------- stream FIFO ----------------
    assign fifo_pop = !fifo_empty && dbg_rd_rdy;

    cap_rd_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (dbg_ret),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign dbg_rd_vld  = !fifo_empty;
    // Gated so the output reads zero out of reset even though FIFO storage is not cleared.
    assign dbg_rd_data = fifo_empty ? '0 : fifo_dout[DW-1:0];

`ifdef CAP_RD_ADDR_TAG_EN
    logic [AW-1:0] addr_q, ret_addr, cap_addr_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_q     <= '0;
            cap_addr_q <= '0;
        end else begin
            addr_q <= req_addr;
            if (host_ret) cap_addr_q <= ret_addr;
        end
    end

    bus_delay #(.W(AW), .DEPTH(RAM_READ_DELAY)) u_addr_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (addr_q),
        .q_o   (ret_addr)
    );

    assign fifo_din          = {ret_addr, ret_data};
    assign capture_rd_addr_o = cap_addr_q;
    assign dbg_rd_addr_o     = fifo_empty ? '0 : fifo_dout[FW-1:DW];
`else
    assign fifo_din = ret_data;
`endif

    // ---------------- in-flight stream reads ----------------
    always_comb begin
        infl_d = infl_q;
        if (dbg_req && !dbg_ret)      infl_d = infl_q + CW'(1);
        else if (!dbg_req && dbg_ret) infl_d = infl_q - CW'(1);
    end

    // ---------------- stream FSM ----------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ptr_lo_inc = ptr_q[BANK_AW-1:0] + BANK_AW'(1);
        // A pointer already past the limit never matches and wraps through all-ones.
        if (store_mode)
            ptr_nxt = (ptr_q[BANK_AW-1:0] == capture_max_addr[BANK_AW-1:0]) ? '0 : AW'(ptr_lo_inc);
        else
            ptr_nxt = (ptr_q == capture_max_addr) ? '0 : ptr_q + AW'(1);

        case (state_q)
            ST_IDLE: begin
                ptr_d = '0;
                if (dbg_rd_en && active) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (dbg_req) ptr_d = ptr_nxt;
                if (!dbg_rd_en || !active) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (infl_q == '0 && fifo_empty) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            infl_q  <= infl_d;
        end
    end

endmodule

// File: tb/tb_cap_ram_rd_mb.sv
// Self-checking bench for cap_ram_rd_mb at default parameters.
// A simple bank model returns a word derived from (bank, address) two cycles
// after each enable; a reference model predicts host returns and the stream
// word sequence from address arithmetic alone.
module tb_cap_ram_rd_mb;

    localparam int NB = 4, BDW = 16, BAW = 13, RD = 2, MW = 4, FD = 8;
    localparam int AW = 15, DW = 64;
    localparam logic [MW-1:0] DBGM = 4'hA;
    localparam logic [MW-1:0] HOSTM = 4'h3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [MW-1:0]     capture_mode, cap_dbg_mode;
    logic              store_mode;
    logic [AW-1:0]     capture_max_addr;
    logic              capture_rd_en;
    logic [AW-1:0]     capture_rd_addr;
    logic              capture_rd_vld;
    logic [DW-1:0]     capture_rd_data;
    logic              dbg_rd_en, dbg_rd_vld, dbg_rd_rdy;
    logic [DW-1:0]     dbg_rd_data;
    logic [NB-1:0]     ram_rd_en;
    logic [NB*BAW-1:0] ram_raddr;
    logic [NB*BDW-1:0] ram_rdata;

    always #5 clk = ~clk;

    cap_ram_rd_mb #(
        .NUM_BANKS(NB), .BANK_DW(BDW), .BANK_AW(BAW),
        .RAM_READ_DELAY(RD), .MODE_WIDTH(MW), .FIFO_DEPTH(FD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .capture_mode     (capture_mode),
        .cap_dbg_mode     (cap_dbg_mode),
        .store_mode       (store_mode),
        .capture_max_addr (capture_max_addr),
        .capture_rd_en    (capture_rd_en),
        .capture_rd_addr  (capture_rd_addr),
        .capture_rd_vld   (capture_rd_vld),
        .capture_rd_data  (capture_rd_data),
        .dbg_rd_en        (dbg_rd_en),
        .dbg_rd_vld       (dbg_rd_vld),
        .dbg_rd_rdy       (dbg_rd_rdy),
        .dbg_rd_data      (dbg_rd_data),
        .ram_rd_en        (ram_rd_en),
        .ram_raddr        (ram_raddr),
        .ram_rdata        (ram_rdata)
    );

    // ---------------- bank contents ----------------
    function automatic logic [15:0] bw(input int b, input logic [12:0] a);
        return 16'(b * 4919) ^ {3'b0, a};
    endfunction

    // Bank model: output register holds its last value, 2-cycle read latency.
    logic [NB-1:0][BDW-1:0] s0 = '0, s1 = '0;
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (ram_rd_en[b]) s0[b] <= bw(b, ram_raddr[b*BAW +: BAW]);
        s1 <= s0;
    end
    assign ram_rdata = s1;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ram_word(input logic [14:0] a, input bit wide);
        logic [63:0] r = '0;
        if (wide) for (int b = 0; b < NB; b++) r[b*16 +: 16] = bw(b, a[12:0]);
        else      r[15:0] = bw(int'(a[14:13]), a[12:0]);
        return r;
    endfunction

    function automatic logic [14:0] nxt(input logic [14:0] a);
        if (store_mode) return (a[12:0] == capture_max_addr[12:0]) ? 15'd0 : {2'b0, a[12:0] + 13'd1};
        return (a == capture_max_addr) ? 15'd0 : a + 15'd1;
    endfunction

    typedef struct { int due; logic [63:0] d; } hexp_t;
    hexp_t        hq[$];
    logic [63:0]  last_h;
    logic [14:0]  s_addr;
    int           n_iss, n_pop, cyc;
    bit           hold_v;
    logic [63:0]  hold_d;
    int           n_chk, n_fail;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One cycle: sample at the falling edge, check, then drive rdy for the next rising edge.
    task automatic tick(input bit rdy);
        bit ev;
        @(negedge clk);
        cyc++;
        if (ram_rd_en != '0) n_iss++;
        ev = (hq.size() > 0) && (hq[0].due == cyc);
        chk("host_vld", capture_rd_vld, ev);
        if (ev) begin
            chk("host_data", capture_rd_data, hq[0].d);
            last_h = hq[0].d;
            void'(hq.pop_front());
        end else begin
            chk("host_hold", capture_rd_data, last_h);
        end
        if (hold_v) begin
            chk("dbg_vld_hold", dbg_rd_vld, 1);
            chk("dbg_data_hold", dbg_rd_data, hold_d);
        end
        hold_v = dbg_rd_vld && !rdy;
        hold_d = dbg_rd_data;
        if (dbg_rd_vld && rdy) begin
            chk("dbg_data", dbg_rd_data, ram_word(s_addr, store_mode));
            n_pop++;
            s_addr = nxt(s_addr);
        end
        dbg_rd_rdy = rdy;
    endtask

    task automatic host_rd(input logic [14:0] a);
        hexp_t e;
        capture_rd_en   = 1'b1;
        capture_rd_addr = a;
        if (capture_mode != DBGM) begin
            e.due = cyc + RD + 2;
            e.d   = ram_word(a, store_mode);
            hq.push_back(e);
        end
    endtask

    task automatic stream_start(input bit wide, input logic [14:0] mx);
        store_mode       = wide;
        capture_max_addr = mx;
        capture_mode     = DBGM;
        s_addr = '0; n_iss = 0; n_pop = 0;
        dbg_rd_en = 1'b1;
    endtask

    task automatic stream_stop();
        int k = 0;
        dbg_rd_en = 1'b0;
        while ((n_pop != n_iss || dbg_rd_vld) && k < 200) begin
            tick(1'b1);
            k++;
        end
        chk("drain_in_time", k < 200, 1);
        chk("drain_count", n_pop, n_iss);
        repeat (4) tick(1'b1);
        chk("idle_quiet", n_pop == n_iss && !dbg_rd_vld, 1);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_cap_vld"},  capture_rd_vld, 0);
        chk({pfx, "_cap_data"}, capture_rd_data, 0);
        chk({pfx, "_dbg_vld"},  dbg_rd_vld, 0);
        chk({pfx, "_dbg_data"}, dbg_rd_data, 0);
        chk({pfx, "_ram_en"},   ram_rd_en, 0);
        chk({pfx, "_ram_addr"}, ram_raddr, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; n_iss = 0; n_pop = 0;
        last_h = '0; s_addr = '0; hold_v = 0; hold_d = '0;
        rst_n = 1'b1;
        capture_mode = HOSTM; cap_dbg_mode = DBGM; store_mode = 1'b0;
        capture_max_addr = '0; capture_rd_en = 1'b0; capture_rd_addr = '0;
        dbg_rd_en = 1'b0; dbg_rd_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk_outputs_zero("rst");
        rst_n = 1'b0;
        repeat (2) tick(1'b1);

        // Deep host read: bank 1 only, offset 5
        host_rd(15'h2005);
        tick(1'b1);
        capture_rd_en = 1'b0;
        chk("deep_en", ram_rd_en, 4'b0010);
        chk("deep_addr", ram_raddr[1*BAW +: BAW], 13'h0005);
        repeat (5) tick(1'b1);

        // Wide host read: every bank, same offset
        store_mode = 1'b1;
        host_rd(15'h0123);
        tick(1'b1);
        capture_rd_en = 1'b0;
        chk("wide_en", ram_rd_en, 4'hF);
        for (int b = 0; b < NB; b++) chk("wide_addr", ram_raddr[b*BAW +: BAW], 13'h0123);
        repeat (5) tick(1'b1);

        // Address extremes back to back, deep
        store_mode = 1'b0;
        host_rd(15'h7FFF); tick(1'b1);
        host_rd(15'h0000); tick(1'b1);
        capture_rd_en = 1'b0;
        repeat (5) tick(1'b1);

        // Random host traffic with mixed store modes; dbg mode suppresses reads
        for (int i = 0; i < 80; i++) begin
            tick(1'b1);
            capture_mode = ($urandom_range(0, 4) == 0) ? DBGM : HOSTM;
            store_mode   = 1'($urandom);
            if ($urandom_range(0, 1) == 1) host_rd(15'($urandom));
            else                           capture_rd_en = 1'b0;
        end
        tick(1'b1);
        capture_rd_en = 1'b0;
        repeat (6) tick(1'b1);

        // Host read in flight when mode switches to dbg: still returned
        capture_mode = HOSTM; store_mode = 1'b0;
        host_rd(15'h5A5A);
        tick(1'b1);
        capture_mode = DBGM;
        host_rd(15'h1111);               // ignored: dbg mode
        tick(1'b1);
        capture_rd_en = 1'b0;
        chk("dbg_mode_no_host_rd", ram_rd_en, 4'b0000);
        repeat (5) tick(1'b1);

        // Stream, deep, wrap at 5, sink always ready
        stream_start(1'b0, 15'd5);
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            if (i >= 6) chk("stream_vld_cont", dbg_rd_vld, 1);
        end
        stream_stop();

        // Restart begins again at address 0
        stream_start(1'b0, 15'd5);
        repeat (12) tick(1'b1);
        stream_stop();

        // Backpressure: credits cap the reads issued at FIFO depth
        stream_start(1'b0, 15'h7FFF);
        repeat (20) tick(1'b0);
        chk("stall_issued", n_iss, FD);
        chk("stall_vld", dbg_rd_vld, 1);
        repeat (40) tick(1'($urandom));
        stream_stop();

        // Wide streams with random limits and random sink readiness
        for (int s = 0; s < 2; s++) begin
            stream_start(1'b1, 15'($urandom_range(2, 20)));
            repeat (60) tick(1'($urandom));
            stream_stop();
        end

        // Deep stream with random readiness, drop enable mid-traffic
        stream_start(1'b0, 15'($urandom_range(1, 30)));
        repeat (50) tick(1'($urandom));
        stream_stop();

        // Reset in the middle of a stream
        stream_start(1'b0, 15'h10);
        repeat (10) tick(1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        hq.delete();
        last_h = '0; s_addr = '0; hold_v = 0; n_iss = 0; n_pop = 0;
        dbg_rd_en = 1'b0; dbg_rd_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick(1'b1);

        // Host path alive after reset
        capture_mode = HOSTM; store_mode = 1'b0;
        host_rd(15'h4ABC);
        tick(1'b1);
        capture_rd_en = 1'b0;
        repeat (6) tick(1'b1);
        chk("host_queue_empty", hq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
